draw_port_arbiter: RTL and testbench

Shares the single VGA adapter write port (x, y, colour, plot) among the game's draw engines: start screen, map 1/map 2 background, car draw and car erase. Each engine requests the port, receives an exclusive grant held for a whole burst, and releases it with a done pulse. Round-robin arbitration keeps the car engines from starving behind a full-screen map fill. Sits between the draw engines and the VGA adapter, below the game control FSM.

---
 rtl/draw_arb_pkg.sv | 24 ++
 rtl/draw_port_arbiter_rr_pick.sv | 28 ++
 rtl/draw_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_draw_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_arb_pkg.sv
// rtl/draw_arb_pkg.sv - shared types and constants for the VGA draw port arbiter
package draw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int REQ_START     = 0;
  localparam int REQ_MAP       = 1;
  localparam int REQ_CAR_DRAW  = 2;
  localparam int REQ_CAR_ERASE = 3;

  localparam int DEF_NUM_REQ        = REQ_CAR_ERASE + 1;
  localparam int DEF_X_W            = $clog2(SCREEN_W);
  localparam int DEF_Y_W            = $clog2(SCREEN_H);
  localparam int DEF_COLOUR_W       = 3;
  localparam int DEF_TIMEOUT_CYCLES = 20000;

endpackage

// File: rtl/draw_port_arbiter_rr_pick.sv
// rtl/draw_port_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  // Scan starts one past the last owner so the last owner is checked last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// rtl/draw_port_arbiter.sv - round-robin owner of the VGA write port
// Optional watchdog revoke enabled by DRAW_ARB_TIMEOUT_EN.
module draw_port_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int X_W            = DEF_X_W,
  parameter int Y_W            = DEF_Y_W,
  parameter int COLOUR_W       = DEF_COLOUR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           done,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  input  logic [NUM_REQ-1:0]           req_plot,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_winner;
  logic                 pick_valid;

  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOUR_W-1:0]  sel_colour;
  logic                 sel_plot;
  logic                 sel_done;
  logic                 sel_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner[i]) pick_idx = PTR_W'(i);
    end
  end

  // ptr doubles as the owner index while BUSY, so only the owner is muxed.
  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_plot   = 1'b0;
    sel_done   = 1'b0;
    sel_req    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ptr == PTR_W'(i)) begin
        sel_x      = req_x[i*X_W +: X_W];
        sel_y      = req_y[i*Y_W +: Y_W];
        sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
        sel_plot   = req_plot[i];
        sel_done   = done[i];
        sel_req    = req[i];
      end
    end
  end

`ifdef DRAW_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] to_cnt;
  logic             to_err;
  logic             to_hit;

  assign to_hit      = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      ptr        <= PTR_W'(NUM_REQ - 1);
      grant      <= '0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
      to_cnt     <= '0;
      to_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (pick_valid) begin
            grant <= pick_winner;
            busy  <= 1'b1;
            ptr   <= pick_idx;
            state <= BUSY;
`ifdef DRAW_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          vga_x      <= sel_x;
          vga_y      <= sel_y;
          vga_colour <= sel_colour;
          vga_plot   <= sel_plot;
          if (sel_done || !sel_req) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= RELEASE;
          end
`ifdef DRAW_ARB_TIMEOUT_EN
          else if (to_hit) begin
            grant  <= '0;
            busy   <= 1'b0;
            to_err <= 1'b1;
            state  <= RELEASE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          grant    <= '0;
          busy     <= 1'b0;
          vga_plot <= 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
          to_err   <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// tb/tb_draw_port_arbiter.sv - self-checking bench for draw_port_arbiter
module tb_draw_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int C_W     = 3;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      done;
  logic [NUM_REQ*X_W-1:0]  req_x;
  logic [NUM_REQ*Y_W-1:0]  req_y;
  logic [NUM_REQ*C_W-1:0]  req_colour;
  logic [NUM_REQ-1:0]      req_plot;
  logic [NUM_REQ-1:0]      grant;
  logic                    busy;
  logic [X_W-1:0]          vga_x;
  logic [Y_W-1:0]          vga_y;
  logic [C_W-1:0]          vga_colour;
  logic                    vga_plot;
  logic                    timeout_err;

  always #5 clk = ~clk;

  draw_port_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .X_W            (X_W),
    .Y_W            (Y_W),
    .COLOUR_W       (C_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .done        (done),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_colour  (req_colour),
    .req_plot    (req_plot),
    .grant       (grant),
    .busy        (busy),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_exp;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   plot_seen    = 0;

  // Every vga_plot cycle must match the next queued pixel from the owner.
  always @(negedge clk) begin
    if (resetn === 1'b1 && vga_plot === 1'b1) begin
      plot_seen++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL vga_unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot", vga_x, vga_y, vga_colour);
      end else begin
        mon_exp = exp_q.pop_front();
        if (vga_x !== mon_exp.x || vga_y !== mon_exp.y || vga_colour !== mon_exp.c) begin
          tests_failed++;
          $display("FAIL vga_pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   vga_x, vga_y, vga_colour, mon_exp.x, mon_exp.y, mon_exp.c);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int r, input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    req_x[r*X_W +: X_W]      = x;
    req_y[r*Y_W +: Y_W]      = y;
    req_colour[r*C_W +: C_W] = c;
  endtask

  task automatic drive_plot(input int r, input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    pix_t p;
    set_pix(r, x, y, c);
    req_plot[r] = 1'b1;
    p.x = x; p.y = y; p.c = c;
    exp_q.push_back(p);
  endtask

  task automatic wait_grant(input int budget, output logic [NUM_REQ-1:0] g, output int n);
    g = '0;
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (grant !== '0) begin
        g = grant;
        break;
      end
    end
    if (g === '0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_grant_timeout: no grant after %0d cycles", n);
    end
  endtask

  task automatic reset_dut;
    resetn     = 1'b0;
    req        = '0;
    done       = '0;
    req_plot   = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; req = 4'b1111; done = '0; req_plot = '0;
    req_x = '0; req_y = '0; req_colour = '0;
    tick();
    tick();
    tests_run++;
    if (grant !== 4'b0000 || busy !== 1'b0 || vga_plot !== 1'b0 || vga_x !== '0 ||
        vga_y !== '0 || vga_colour !== '0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got grant=%b busy=%b plot=%b x=%0d y=%0d c=%0d err=%b, expected all 0",
               grant, busy, vga_plot, vga_x, vga_y, vga_colour, timeout_err);
    end
    resetn = 1'b1;
    tick();
    tests_run++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got grant=%b busy=%b, expected 0001 1", grant, busy);
    end
    req = '0;
    tick();
    tests_run++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abandon_release: got grant=%b busy=%b, expected 0000 0", grant, busy);
    end
    tick();
  endtask

  task automatic test_single_plot;
    int p0;
    reset_dut();
    req[2] = 1'b1;
    tick();
    tests_run++;
    if (grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_grant: got %b, expected 0100", grant);
    end
    p0 = plot_seen;
    for (int k = 0; k < 3; k++) begin
      drive_plot(2, 8'd10, 7'd20, 3'b101);
      tick();
      tests_run++;
      if (vga_plot !== 1'b1 || vga_x !== 8'd10 || vga_y !== 7'd20 || vga_colour !== 3'b101) begin
        tests_failed++;
        $display("FAIL single_plot_latency: got plot=%b x=%0d y=%0d c=%b, expected 1 10 20 101",
                 vga_plot, vga_x, vga_y, vga_colour);
      end
    end
    req_plot = '0;
    done[2]  = 1'b1;
    tick();
    done = '0;
    tests_run++;
    if (grant !== 4'b0000 || busy !== 1'b0 || vga_plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_release: got grant=%b busy=%b plot=%b, expected 0000 0 0", grant, busy, vga_plot);
    end
    req = '0;
    tick();
    tick();
    tests_run++;
    if (plot_seen - p0 !== 3) begin
      tests_failed++;
      $display("FAIL single_plot_count: got %0d, expected 3", plot_seen - p0);
    end
  endtask

  task automatic test_round_robin;
    logic [NUM_REQ-1:0] gq[$];
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] eg;
    int n;
    int owner;
    gq = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_grant(8, g, n);
      eg = gq.pop_front();
      tests_run++;
      if (g !== eg) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got %b, expected %b", b, g, eg);
      end
      if (b > 0) begin
        tests_run++;
        if (n !== 2) begin
          tests_failed++;
          $display("FAIL rr_gap[%0d]: got %0d cycles, expected 2", b, n);
        end
      end
      owner = 0;
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) owner = i;
      for (int k = 0; k < 2; k++) begin
        drive_plot(owner, X_W'($urandom_range(0, 159)), Y_W'($urandom_range(0, 119)), C_W'($urandom_range(0, 7)));
        tick();
      end
      req_plot    = '0;
      done[owner] = 1'b1;
      tick();
      done = '0;
      tests_run++;
      if (grant !== 4'b0000 || vga_plot !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_release[%0d]: got grant=%b plot=%b, expected 0000 0", b, grant, vga_plot);
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_ignore_other;
    logic [NUM_REQ-1:0] g;
    int n;
    reset_dut();
    req = 4'b1010;
    tick();
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL ignore_first_grant: got %b, expected 0010", grant);
    end
    set_pix(3, 8'd99, 7'd1, 3'b111);
    req_plot[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_plot(1, X_W'(40 + k), 7'd5, 3'b010);
      if (k == 1) done[3] = 1'b1;
      tick();
      done[3] = 1'b0;
      tests_run++;
      if (grant !== 4'b0010 || vga_x === 8'd99) begin
        tests_failed++;
        $display("FAIL ignore_other_requester: got grant=%b x=%0d, expected 0010 and x!=99", grant, vga_x);
      end
    end
    req_plot = '0;
    done[1]  = 1'b1;
    tick();
    done = '0;
    wait_grant(8, g, n);
    tests_run++;
    if (g !== 4'b1000 || n !== 2) begin
      tests_failed++;
      $display("FAIL ignore_next_grant: got %b after %0d, expected 1000 after 2", g, n);
    end
    done[3] = 1'b1;
    tick();
    done = '0;
    req  = '0;
    tick();
    tick();
  endtask

  task automatic test_abandon;
    logic [NUM_REQ-1:0] g;
    int n;
    reset_dut();
    req = 4'b0110;
    tick();
    drive_plot(1, 8'd7, 7'd8, 3'b011);
    tick();
    req_plot = '0;
    req[1]   = 1'b0;
    tick();
    tests_run++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abandon_release: got grant=%b busy=%b, expected 0000 0", grant, busy);
    end
    wait_grant(8, g, n);
    tests_run++;
    if (g !== 4'b0100 || n !== 2) begin
      tests_failed++;
      $display("FAIL abandon_next_grant: got %b after %0d, expected 0100 after 2", g, n);
    end
    done[2] = 1'b1;
    tick();
    done = '0;
    req  = '0;
    tick();
    tick();
  endtask

`ifdef DRAW_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [NUM_REQ-1:0] g;
    int n;
    int ncyc;
    int errs;
    reset_dut();
    req = 4'b0011;
    tick();
    ncyc = (grant === 4'b0001) ? 1 : 0;
    errs = 0;
    while (ncyc > 0 && ncyc < 40) begin
      tick();
      if (timeout_err === 1'b1) errs++;
      if (grant === 4'b0001) ncyc++;
      else break;
    end
    tests_run++;
    if (ncyc !== 16 || timeout_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_revoke: got %0d granted cycles err=%b, expected 16 and 1", ncyc, timeout_err);
    end
    tick();
    tests_run++;
    if (timeout_err !== 1'b0 || errs !== 1) begin
      tests_failed++;
      $display("FAIL timeout_pulse: got err=%b pulses=%0d, expected 0 and 1", timeout_err, errs);
    end
    wait_grant(8, g, n);
    tests_run++;
    if (g !== 4'b0010) begin
      tests_failed++;
      $display("FAIL timeout_next_grant: got %b, expected 0010", g);
    end
    done[1] = 1'b1;
    tick();
    done = '0;
    req  = '0;
    tick();
    tick();
  endtask
`else
  task automatic test_no_timeout;
    int bad;
    reset_dut();
    req = 4'b0001;
    tick();
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (grant !== 4'b0001 || timeout_err !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL hold_without_watchdog: got %0d bad cycles, expected 0", bad);
    end
    req = '0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_plot();
    test_round_robin();
    test_ignore_other();
    test_abandon();
`ifdef DRAW_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending pixels, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
